// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: slice-width
// derivation, configuration sanity checks and status flag packing.
package pipe_adder_pkg;

    // Bit positions of the flags inside the packed status field
    localparam int FLAG_CARRY_BIT = 0;
    localparam int FLAG_OVF_BIT   = 1;
    localparam int FLAG_WIDTH     = 2;

    // Width of one carry-chained slice
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // A configuration is usable only when the operand splits into equal,
    // non-empty slices
    function automatic bit config_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Pack carry and overflow into the status field
    function automatic logic [FLAG_WIDTH-1:0] pack_flags(input logic carry, input logic ovf);
        logic [FLAG_WIDTH-1:0] flags;
        flags = '0;
        flags[FLAG_CARRY_BIT] = carry;
        flags[FLAG_OVF_BIT]   = ovf;
        return flags;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit slice of the carry chain. Behaves as a ripple of
// full adders; also exposes the carry into its MSB so the top slice can
// derive signed overflow.
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cin_msb
);

    logic [W:0] total;

    assign total   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum     = total[W-1:0];
    assign cout    = total[W];
    // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out directly
    assign cin_msb = a[W-1] ^ b[W-1] ^ total[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor. The add is split into STAGES
// slices, one register stage each. Upper operand slices are skewed so they
// meet their carry, finished lower sum slices ride along so the result
// leaves aligned. The whole pipeline advances or holds as one unit under a
// valid/ready handshake.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!config_ok(WIDTH, STAGES)) begin : g_bad_config
        $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // Per-stage registers, indexed [stage][slice]
    logic [CHUNK-1:0]      a_pipe   [STAGES][STAGES];
    logic [CHUNK-1:0]      b_pipe   [STAGES][STAGES];
    logic [CHUNK-1:0]      sum_pipe [STAGES][STAGES];
    logic                  carry_q  [STAGES];
    logic [STAGES-1:0]     valid_q;
    logic [FLAG_WIDTH-1:0] flags_q;

    // Slice cell connections
    logic [CHUNK-1:0] sl_a    [STAGES];
    logic [CHUNK-1:0] sl_b    [STAGES];
    logic [CHUNK-1:0] sl_sum  [STAGES];
    logic             sl_cin  [STAGES];
    logic             sl_cout [STAGES];
    logic             sl_cmsb [STAGES];

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign advance   = !valid_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign b_eff     = in_sub ? ~in_b : in_b;
    assign c0        = in_sub ? 1'b1 : in_cin;
    assign out_valid = valid_q[STAGES-1];
    assign out_carry = flags_q[FLAG_CARRY_BIT];
    assign out_ovf   = flags_q[FLAG_OVF_BIT];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign sl_a[k]   = in_a[CHUNK-1:0];
            assign sl_b[k]   = b_eff[CHUNK-1:0];
            assign sl_cin[k] = c0;
        end else begin : g_rest
            assign sl_a[k]   = a_pipe[k-1][k];
            assign sl_b[k]   = b_pipe[k-1][k];
            assign sl_cin[k] = carry_q[k-1];
        end

        adder_slice #(
            .W(CHUNK)
        ) u_slice (
            .a      (sl_a[k]),
            .b      (sl_b[k]),
            .cin    (sl_cin[k]),
            .sum    (sl_sum[k]),
            .cout   (sl_cout[k]),
            .cin_msb(sl_cmsb[k])
        );
    end

    // Reassemble the aligned result from the last stage's sum slices
    always_comb begin
        out_sum = '0;
        for (int j = 0; j < STAGES; j++) begin
            out_sum[j*CHUNK +: CHUNK] = sum_pipe[STAGES-1][j];
        end
    end

    // Advance every stage together, or hold all of them while the output stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            flags_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                carry_q[k] <= 1'b0;
                for (int j = 0; j < STAGES; j++) begin
                    a_pipe[k][j]   <= '0;
                    b_pipe[k][j]   <= '0;
                    sum_pipe[k][j] <= '0;
                end
            end
        end else if (advance) begin
            valid_q[0] <= in_valid && in_ready;
            carry_q[0] <= sl_cout[0];
            for (int j = 0; j < STAGES; j++) begin
                a_pipe[0][j]   <= in_a[j*CHUNK +: CHUNK];
                b_pipe[0][j]   <= b_eff[j*CHUNK +: CHUNK];
                sum_pipe[0][j] <= (j == 0) ? sl_sum[0] : '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                carry_q[k] <= sl_cout[k];
                for (int j = 0; j < STAGES; j++) begin
                    a_pipe[k][j]   <= a_pipe[k-1][j];
                    b_pipe[k][j]   <= b_pipe[k-1][j];
                    sum_pipe[k][j] <= (j == k) ? sl_sum[k] : sum_pipe[k-1][j];
                end
            end
            flags_q <= pack_flags(sl_cout[STAGES-1], sl_cmsb[STAGES-1] ^ sl_cout[STAGES-1]);
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder: a 32/4 instance carries the
// main scenarios, and three extra instances (8/1, 16/2, 32/32) repeat the
// arithmetic, latency and back-pressure checks.
module tb_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [31:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_carry, out_ovf;

    logic [2:0]  sw_in_valid, sw_in_ready, sw_out_valid, sw_carry, sw_ovf, sw_cin, sw_sub;
    logic        sw_out_ready;
    logic [31:0] sw_a [3];
    logic [31:0] sw_b [3];
    logic [31:0] sw_sum [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int cfg_w(input int i);
        return (i == 0) ? 8 : (i == 1) ? 16 : 32;
    endfunction

    function automatic int cfg_s(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 32;
    endfunction

    pipe_adder #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry),
        .out_ovf  (out_ovf)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W = cfg_w(g);
        localparam int S = cfg_s(g);
        logic [W-1:0] o_sum;

        pipe_adder #(
            .WIDTH (W),
            .STAGES(S)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (sw_in_valid[g]),
            .in_ready (sw_in_ready[g]),
            .in_a     (sw_a[g][W-1:0]),
            .in_b     (sw_b[g][W-1:0]),
            .in_cin   (sw_cin[g]),
            .in_sub   (sw_sub[g]),
            .out_valid(sw_out_valid[g]),
            .out_ready(sw_out_ready),
            .out_sum  (o_sum),
            .out_carry(sw_carry[g]),
            .out_ovf  (sw_ovf[g])
        );

        assign sw_sum[g] = 32'(o_sum);
    end

    // Reference: flat add of width w, returns {ovf, carry, sum}
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        logic [32:0] m, aa, bb, full;
        logic        c0, carry, cmsb;
        m     = (33'd1 << w) - 33'd1;
        aa    = {1'b0, a} & m;
        bb    = {1'b0, (sub ? ~b : b)} & m;
        c0    = sub ? 1'b1 : cin;
        full  = aa + bb + {32'd0, c0};
        carry = full[w];
        cmsb  = aa[w-1] ^ bb[w-1] ^ full[w-1];
        return {cmsb ^ carry, carry, full[31:0] & m[31:0]};
    endfunction

    // Width-scaled boundary and ordinary vectors for the sweep
    function automatic void get_vec(input int idx, input int w, output logic [31:0] a,
                                    output logic [31:0] b, output logic cin, output logic sub);
        logic [31:0] m;
        m   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        cin = 1'b0;
        sub = 1'b0;
        b   = 32'd1;
        case (idx)
            0:       a = m;
            1:       a = m >> 1;
            2:       begin a = 32'h10; b = 32'h20; cin = 1'b1; end
            3:       begin a = 32'd5; b = 32'd7; sub = 1'b1; end
            4:       begin a = 32'd1 << (w - 1); sub = 1'b1; end
            5:       begin a = 32'd1 << (w - 1); sub = 1'b1; cin = 1'b1; end
            6:       begin a = 32'h1234_5678 & m; b = 32'h9ABC_DEF0 & m; end
            default: begin a = 32'hDEAD_BEEF & m; b = 32'hCAFE_F00D & m; sub = 1'b1; end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (STAGES + 2) tick();
    endtask

    // Present one beat with out_ready high and wait (bounded) for its result
    task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                            output logic [31:0] sum, output logic carry, output logic ovf, output int lat);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        sum   = out_sum;
        carry = out_carry;
        ovf   = out_ovf;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_sum !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_sum got %h want 00000000", out_sum); end
        checks++; if ({out_carry, out_ovf} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b%b want 00", out_carry, out_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (sw_out_valid !== 3'b000) begin errors++; $display("[TB] FAIL reset_sweep_valid got %b want 000", sw_out_valid); end
        #9 rst_n = 1'b1;
        tick();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL post_reset_handshake got %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_carry_ripple();
        logic [31:0] s;
        logic        c, o;
        int          lat;
        run_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat);
        checks++; if (lat !== STAGES) begin errors++; $display("[TB] FAIL ripple_latency got %0d want %0d", lat, STAGES); end
        checks++; if (s !== 32'h0000_0000) begin errors++; $display("[TB] FAIL ripple_sum got %h want 00000000", s); end
        checks++; if (c !== 1'b1) begin errors++; $display("[TB] FAIL ripple_carry got %b want 1", c); end
        checks++; if (o !== 1'b0) begin errors++; $display("[TB] FAIL ripple_ovf got %b want 0", o); end
    endtask

    task automatic test_add_overflow();
        logic [31:0] s;
        logic        c, o;
        int          lat;
        run_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat);
        checks++; if ({o, c, s} !== {1'b1, 1'b0, 32'h8000_0000}) begin errors++; $display("[TB] FAIL add_ovf got ovf=%b c=%b s=%h want ovf=1 c=0 s=80000000", o, c, s); end
        run_beat(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, s, c, o, lat);
        checks++; if ({o, c, s} !== {1'b0, 1'b0, 32'h0000_0031}) begin errors++; $display("[TB] FAIL add_cin got ovf=%b c=%b s=%h want ovf=0 c=0 s=00000031", o, c, s); end
        checks++; if (lat !== STAGES) begin errors++; $display("[TB] FAIL add_cin_latency got %0d want %0d", lat, STAGES); end
    endtask

    task automatic test_subtract();
        logic [31:0] s;
        logic        c, o;
        int          lat;
        for (int r = 0; r < 2; r++) begin
            run_beat(32'd5, 32'd7, (r == 1), 1'b1, s, c, o, lat);
            checks++; if ({o, c, s} !== {1'b0, 1'b0, 32'hFFFF_FFFE}) begin errors++; $display("[TB] FAIL sub_5_7 cin=%0d got ovf=%b c=%b s=%h want ovf=0 c=0 s=fffffffe", r, o, c, s); end
            run_beat(32'h8000_0000, 32'd1, (r == 1), 1'b1, s, c, o, lat);
            checks++; if ({o, c, s} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin errors++; $display("[TB] FAIL sub_minneg cin=%0d got ovf=%b c=%b s=%h want ovf=1 c=1 s=7fffffff", r, o, c, s); end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] ta [8];
        logic [31:0] tb [8];
        logic [33:0] held, exp;
        logic        stall;
        int          sent, recv;
        ta = '{32'h1357_9BDF, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h0000_0001,
               32'h8000_0000, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hFFFF_FFFF};
        tb = '{32'h2468_ACE0, 32'h0001_FFFF, 32'h7FFF_FFFF, 32'h0000_0002,
               32'h8000_0000, 32'h5A5A_5A5A, 32'hF0F0_F0F1, 32'hFFFF_FFFF};
        sent = 0;
        recv = 0;
        held = '0;
        drain();
        for (int cyc = 0; cyc < 30; cyc++) begin
            stall     = (cyc >= 6) && (cyc <= 8);
            out_ready = !stall;
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_a   = ta[sent];
                in_b   = tb[sent];
                in_cin = sent[0];
                in_sub = sent[1];
            end
            #1;
            checks++; if (in_ready !== !stall) begin errors++; $display("[TB] FAIL bp_in_ready cycle %0d got %b want %b", cyc, in_ready, !stall); end
            if (cyc == 6) held = {out_ovf, out_carry, out_sum};
            if (stall && cyc > 6) begin
                checks++; if ({out_valid, out_ovf, out_carry, out_sum} !== {1'b1, held}) begin errors++; $display("[TB] FAIL bp_stable cycle %0d got v=%b %h want v=1 %h", cyc, out_valid, {out_ovf, out_carry, out_sum}, held); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (recv >= 8) begin
                    errors++; $display("[TB] FAIL bp_extra_beat got beat %0d want none", recv);
                end else begin
                    exp = ref_add(32, ta[recv], tb[recv], recv[0], recv[1]);
                    if ({out_ovf, out_carry, out_sum} !== exp) begin errors++; $display("[TB] FAIL bp_result beat %0d got %h want %h", recv, {out_ovf, out_carry, out_sum}, exp); end
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (recv !== 8) begin errors++; $display("[TB] FAIL bp_count got %0d want 8", recv); end
    endtask

    task automatic test_reset_mid_flight();
        logic [31:0] s;
        logic        c, o;
        int          lat;
        logic        stale;
        drain();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 32'h1111_0000 + 32'(i);
            in_b     = 32'h0000_2222;
            in_cin   = 1'b0;
            in_sub   = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_pre_valid got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got %b want 0", out_valid); end
        checks++; if ({out_carry, out_ovf, out_sum} !== 34'h0) begin errors++; $display("[TB] FAIL rst_mid_outputs got %h want 0", {out_carry, out_ovf, out_sum}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_ready got %b want 1", in_ready); end
        tick();
        #3 rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_stale got %b want 0", stale); end
        run_beat(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, s, c, o, lat);
        checks++; if (lat !== STAGES) begin errors++; $display("[TB] FAIL rst_mid_latency got %0d want %0d", lat, STAGES); end
        checks++; if ({o, c, s} !== {2'b00, 32'h0000_0300}) begin errors++; $display("[TB] FAIL rst_mid_result got %h want 000000300", {o, c, s}); end
    endtask

    task automatic test_param_sweep();
        logic [31:0] va, vb;
        logic        vc, vs, stall;
        logic [33:0] exp;
        logic        seen [3];
        int          sent [3];
        int          recv [3];
        drain();
        // Latency and carry ripple, all widths at once
        sw_out_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            get_vec(0, cfg_w(g), va, vb, vc, vs);
            sw_a[g] = va; sw_b[g] = vb; sw_cin[g] = vc; sw_sub[g] = vs;
            seen[g] = 1'b0;
        end
        sw_in_valid = 3'b111;
        tick();
        sw_in_valid = 3'b000;
        for (int lat = 1; lat <= 40; lat++) begin
            for (int g = 0; g < 3; g++) begin
                if (!seen[g] && sw_out_valid[g]) begin
                    seen[g] = 1'b1;
                    get_vec(0, cfg_w(g), va, vb, vc, vs);
                    exp = ref_add(cfg_w(g), va, vb, vc, vs);
                    checks++; if (lat !== cfg_s(g)) begin errors++; $display("[TB] FAIL sweep%0d_latency got %0d want %0d", g, lat, cfg_s(g)); end
                    checks++; if ({sw_ovf[g], sw_carry[g], sw_sum[g]} !== exp) begin errors++; $display("[TB] FAIL sweep%0d_ripple got %h want %h", g, {sw_ovf[g], sw_carry[g], sw_sum[g]}, exp); end
                end
            end
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            checks++; if (seen[g] !== 1'b1) begin errors++; $display("[TB] FAIL sweep%0d_timeout got no result want one", g); end
            sent[g] = 0;
            recv[g] = 0;
        end
        // Streaming with a stall, checked in order against the model
        for (int cyc = 0; cyc < 80; cyc++) begin
            stall        = (cyc >= 10) && (cyc <= 12);
            sw_out_ready = !stall;
            for (int g = 0; g < 3; g++) begin
                sw_in_valid[g] = (sent[g] < 8);
                get_vec(sent[g], cfg_w(g), va, vb, vc, vs);
                sw_a[g] = va; sw_b[g] = vb; sw_cin[g] = vc; sw_sub[g] = vs;
            end
            #1;
            for (int g = 0; g < 3; g++) begin
                if (sw_out_valid[g] && sw_out_ready) begin
                    checks++;
                    if (recv[g] >= 8) begin
                        errors++; $display("[TB] FAIL sweep%0d_extra_beat got beat %0d want none", g, recv[g]);
                    end else begin
                        get_vec(recv[g], cfg_w(g), va, vb, vc, vs);
                        exp = ref_add(cfg_w(g), va, vb, vc, vs);
                        if ({sw_ovf[g], sw_carry[g], sw_sum[g]} !== exp) begin errors++; $display("[TB] FAIL sweep%0d_result beat %0d got %h want %h", g, recv[g], {sw_ovf[g], sw_carry[g], sw_sum[g]}, exp); end
                    end
                    recv[g]++;
                end
                if (sw_in_valid[g] && sw_in_ready[g]) sent[g]++;
            end
            tick();
        end
        sw_in_valid = 3'b000;
        for (int g = 0; g < 3; g++) begin
            checks++; if (recv[g] !== 8) begin errors++; $display("[TB] FAIL sweep%0d_count got %0d want 8", g, recv[g]); end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b1;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_cin       = 1'b0;
        in_sub       = 1'b0;
        out_ready    = 1'b1;
        sw_in_valid  = '0;
        sw_out_ready = 1'b1;
        sw_cin       = '0;
        sw_sub       = '0;
        for (int g = 0; g < 3; g++) begin
            sw_a[g] = '0;
            sw_b[g] = '0;
        end
        test_reset();
        test_carry_ripple();
        test_add_overflow();
        test_subtract();
        test_back_pressure();
        test_reset_mid_flight();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
